// File: rtl/index_packer_if.sv
// Bus bundle for index_packer: encoder sample inputs plus the word readout handshake.
// master drives samples and dout_ready; slave is the packer itself.
interface index_packer_if #(
  parameter int log2N      = 2,
  parameter int WORD_WIDTH = 8
);
  logic                  sample;
  logic [log2N-1:0]      P_IN;
  logic                  F_IN;
  logic                  flush;
  logic [WORD_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  overflow;
  logic [15:0]           miss_cnt;

  modport master (
    output sample, P_IN, F_IN, flush, dout_ready,
    input  dout, dout_valid, overflow, miss_cnt
  );

  modport slave (
    input  sample, P_IN, F_IN, flush, dout_ready,
    output dout, dout_valid, overflow, miss_cnt
  );
endinterface

// File: rtl/index_packer.sv
// Packs found encoder indices LSB-first into words and queues them in a FWFT FIFO.
// Optional miss counter enabled by defining INDEX_PACKER_MISS_CNT_EN.
module index_packer #(
  parameter int log2N      = 2,
  parameter int WORD_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  index_packer_if.slave bus
);
  localparam int PACK_COUNT = WORD_WIDTH / log2N;
  localparam int FILL_W     = (PACK_COUNT > 1) ? $clog2(PACK_COUNT) : 1;

  logic [WORD_WIDTH-1:0] acc_reg;
  logic [WORD_WIDTH-1:0] acc_merged;
  logic [FILL_W-1:0]     fill_reg;
  logic                  accept;
  logic                  word_done;
  logic                  push;
  logic                  push_ok;
  logic                  pop;
  logic                  full;
  logic                  not_empty;

  logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_reg;
  logic [FIFO_AW-1:0]    rd_ptr_reg;
  logic [FIFO_AW:0]      count_reg;
  logic                  overflow_reg;

  assign accept    = bus.sample & bus.F_IN;
  assign word_done = accept && (fill_reg == FILL_W'(PACK_COUNT - 1));
  // A flush on an empty word still pushes when a sample lands in that same cycle.
  assign push      = word_done || (bus.flush && (accept || (fill_reg != '0)));

  generate
    for (genvar gi = 0; gi < PACK_COUNT; gi++) begin : g_field
      assign acc_merged[gi*log2N +: log2N] =
        (accept && (fill_reg == FILL_W'(gi))) ? bus.P_IN : acc_reg[gi*log2N +: log2N];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      fill_reg <= '0;
    end else if (push) begin
      acc_reg  <= '0;
      fill_reg <= '0;
    end else if (accept) begin
      acc_reg  <= acc_merged;
      fill_reg <= fill_reg + FILL_W'(1);
    end
  end

  assign not_empty = (count_reg != '0);
  assign full      = (count_reg == (FIFO_AW+1)'(FIFO_DEPTH));
  assign pop       = not_empty & bus.dout_ready;
  // When full, the slot being popped is the one written, so push+pop is safe.
  assign push_ok   = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= acc_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + (FIFO_AW+1)'(1);
        2'b01:   count_reg <= count_reg - (FIFO_AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (push && !push_ok) overflow_reg <= 1'b1;
    end
  end

  assign bus.dout_valid = not_empty;
  assign bus.dout       = not_empty ? mem[rd_ptr_reg] : '0;
  assign bus.overflow   = overflow_reg;

`ifdef INDEX_PACKER_MISS_CNT_EN
  logic [15:0] miss_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miss_cnt_reg <= '0;
    end else if (bus.sample && !bus.F_IN && (miss_cnt_reg != 16'hFFFF)) begin
      miss_cnt_reg <= miss_cnt_reg + 16'd1;
    end
  end

  assign bus.miss_cnt = miss_cnt_reg;
`else
  assign bus.miss_cnt = 16'h0000;
`endif
endmodule

// File: doc/index_packer.md
# index_packer

Downstream consumer of the priority encoder stage. It samples the encoder's index/found pair on a strobe and discards samples where nothing was found. Valid indices are packed LSB-first into fixed-width words, which are buffered in a small first-word-fall-through FIFO and drained through a valid/ready handshake towards the readout path.

## Interface
- `log2N`, default 2: width of each index field; matches the encoder's index width.
- `WORD_WIDTH`, default 8: output word width; must be an integer multiple of `log2N`. `PACK_COUNT = WORD_WIDTH/log2N` (default 4).
- `FIFO_DEPTH`, default 4: word FIFO entries; must be a power of two ≥ 2.
- `FIFO_AW`, default 2: log2(`FIFO_DEPTH`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; **synchronous, active-low**.
- `sample`  in  1  strobe: evaluate `P_IN`/`F_IN` this cycle.
- `P_IN`  in  log2N  encoder index.
- `F_IN`  in  1  encoder found flag.
- `flush`  in  1  push the partial word now.
- `dout`  out  WORD_WIDTH  FIFO head word; 0 when empty.
- `dout_valid`  out  1  FIFO non-empty.
- `dout_ready`  in  1  consumer accepts head.
- `overflow`  out  1  sticky: a word was dropped because the FIFO was full.
- `miss_cnt`  out  16  count of `sample` strobes with `F_IN=0` (see Configuration).

## Operation
**Packer**
- The packer has a shift word `acc` (`WORD_WIDTH` bits) and a field counter `fill` (0..`PACK_COUNT-1`).
- Accepted sample: `sample=1` and `F_IN=1`. It writes `P_IN` into field `fill`, bits [`fill*log2N` +: `log2N`].
- If `fill==PACK_COUNT-1`, the completed word is pushed, then `acc` and `fill` clear to 0. Otherwise `fill` increments.
- `sample=1` with `F_IN=0`: no packing. `miss_cnt` increments, saturating at 0xFFFF.
- `flush=1` with `fill>0`: the current `acc` is pushed, with unfilled upper fields at 0. `acc` and `fill` then clear.
- `flush=1` with `fill==0`: no push, unless an accepted sample arrives in the same cycle.
- `flush` and an accepted sample in the same cycle: the sample is merged into the word first, and a single push occurs.

**FIFO**
- First-word-fall-through.
- Push is allowed when not full, or when full and a pop occurs in the same cycle.
- A push that is not allowed drops the word and sets `overflow`. `overflow` clears only on reset.
- Packing continues normally after a drop.
- Pop occurs when `dout_valid && dout_ready`.
- `dout_ready` while empty has no effect.
- Pointers wrap modulo `FIFO_DEPTH`. Occupancy is a `FIFO_AW+1`-bit counter.

## Timing
- Reset values (`rst_n=0` at a clock edge):
  - `acc=0`, `fill=0`
  - FIFO empty: `dout_valid=0`, `dout=0`
  - `overflow=0`, `miss_cnt=0`
- Reset mid-word or with the FIFO non-empty discards all buffered data.
- Latency: a push at edge t makes `dout_valid=1` with the word on `dout` after edge t, i.e. in cycle t+1.
- Pop at edge t exposes the next entry in cycle t+1.
- Full FIFO plus pop plus push in the same cycle: occupancy is unchanged, and the new word is enqueued at the tail.
- `dout` is stable while `dout_valid=1` and `dout_ready=0`.
- Inputs are sampled only on rising `clk` edges. There are no combinational paths from `sample`, `P_IN`, `F_IN` or `flush` to any output.

## Configuration
- Macro: `INDEX_PACKER_MISS_CNT_EN`.
- Defined: the 16-bit saturating `miss_cnt` counter is implemented as described.
- Undefined: no counter logic is built and `miss_cnt` is tied to 16'h0000. All other behaviour is identical.

## Test plan
All scenarios use default parameters.
- **Pack order:** 4 accepted samples with `P_IN` = 1, 2, 3, 0 and `dout_ready=0`.
  - `dout_valid` rises the cycle after the 4th sample.
  - `dout` = 8'h39.
- **Miss filtering:**
  - Samples (F,P) = (1,3), (0,2), (1,1), (0,0), (1,2), (1,0) → single word 8'h27.
  - With macro defined: `miss_cnt` = 2.
  - With macro undefined: `miss_cnt` = 0.
- **Flush:**
  - 2 accepted samples P = 3, 2, then `flush` → `dout` = 8'h0B.
  - `flush` with `fill=0` → no push.
  - `flush` together with a 3rd sample P=1 after P = 3, 2 → 8'h1B.
- **Overflow:**
  - `dout_ready=0`, push 5 words 8'h00, 8'h55, 8'hAA, 8'hFF, 8'h39.
  - `overflow` = 1; draining yields only the first 4 words, in order.
  - Full FIFO with push and pop in the same cycle → no overflow; the new word appears last.
- **Backpressure:** toggle `dout_ready` randomly while streaming 20 words. Require:
  - no loss or duplication;
  - `dout` held stable while stalled.
- **Reset mid-operation:**
  - `rst_n=0` for 1 cycle with `fill=2` and 3 words queued.
  - Next cycle: `dout_valid=0`, `overflow=0`, `miss_cnt=0`.
  - The following 4 accepted samples form a fresh word.
